axil_master_cmd: RTL
====================

# axil_master_cmd

Single-outstanding AXI4-Lite initiator that turns a simple command/response port into AXI4-Lite read and write transactions. It is the master-side counterpart to the team's AXI4-Lite register slaves, such as the ASIC function interface register block. Firmware models and on-chip sequencers use it to program and poll those register files without PS involvement.

## Interface
Parameters:
- C_M_AXI_ADDR_WIDTH, 9, address width of the AW/AR channels and of cmd_addr.
- C_M_AXI_DATA_WIDTH, 32, data width; must be 32 or 64.

Ports:
- M_AXI_ACLK  in  1  single clock for all logic.
- M_AXI_ARESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  a command is presented.
- cmd_ready  out  1  the block accepts a command this cycle.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR  byte address.
- cmd_wdata  in  DATA  write data.
- cmd_wstrb  in  DATA/8  write strobes.
- rsp_valid  out  1  a response is held.
- rsp_ready  in  1  the consumer accepts the response.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  DATA  read data; 0 for writes.
- rsp_resp  out  2  captured BRESP or RRESP.
- M_AXI_AWADDR/AWPROT/AWVALID out, M_AXI_AWREADY in: write-address channel. AWPROT is fixed at 3'b000.
- M_AXI_WDATA/WSTRB/WVALID out, M_AXI_WREADY in: write-data channel.
- M_AXI_BRESP/BVALID in, M_AXI_BREADY out: write-response channel.
- M_AXI_ARADDR/ARPROT/ARVALID out, M_AXI_ARREADY in: read-address channel. ARPROT is fixed at 3'b000.
- M_AXI_RDATA/RRESP/RVALID in, M_AXI_RREADY out: read-data channel.
- wr_count, rd_count, err_count  out  16 each  statistics; see Configuration.

## Operation
- FSM states are IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA and RESP.
- IDLE
  - cmd_ready = 1.
  - On cmd_valid: latch addr, wdata, wstrb and write. Go to WR_ADDR if write, else RD_ADDR.
- WR_ADDR
  - AWVALID and WVALID are asserted together.
  - Each valid drops independently after its own handshake, tracked by internal aw_done and w_done flags.
  - When both are done, go to WR_RESP. AW and W handshakes in the same cycle are legal.
- WR_RESP
  - BREADY = 1.
  - On BVALID: capture BRESP, set rsp_rdata = 0, go to RESP.
  - A BVALID that arrives before both AW and W handshakes is ignored, because BREADY stays 0 until then.
- RD_ADDR: ARVALID = 1. On ARREADY, go to RD_DATA.
- RD_DATA: RREADY = 1. On RVALID: capture RDATA and RRESP, go to RESP.
- RESP: rsp_valid = 1 and outputs are stable. On rsp_ready, go to IDLE.
- Reset values: cmd_ready = 0 while reset is asserted. Every other output is 0, including all VALID/READY signals, the addresses and the counters.
- Reset mid-transaction: all VALIDs and READYs drop asynchronously. The pending command is discarded with no response. The FSM restarts in IDLE.
- Non-OKAY responses (SLVERR 2'b10, DECERR 2'b11) are passed through unchanged. Errors never trigger a retry.

## Timing
- All AXI and response outputs are registered. No input-to-output combinational paths.
- Write latency, cmd accept to rsp_valid, with a zero-wait slave: 3 cycles.
  - cycle 0: accept.
  - cycle 1: AW/W handshake.
  - cycle 2: B handshake.
  - cycle 3: rsp_valid.
- Read latency with a zero-wait slave: 3 cycles.
- Back-to-back: the earliest next cmd_ready is the cycle after the rsp handshake.
- AXI rule: once asserted, a VALID stays high with stable payload until its handshake.

## Configuration
- AXIL_MASTER_STATS_EN defined:
  - wr_count increments on each completed write.
  - rd_count increments on each completed read.
  - err_count increments on each response with resp[1] = 1.
  - All three saturate at 16'hFFFF and clear on reset.
  - Counts update in the cycle the B or R handshake occurs.
- Not defined: the three ports remain and are tied to 0. No counter logic is generated.

## Structure
- Package axil_master_pkg holds:
  - the state enum axil_master_state_t;
  - resp localparams RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  - the statistics counter width localparam STAT_W = 16.
- Sub-module axil_master_sat_counter: a STAT_W saturating counter with inc and async-reset inputs. It is instantiated three times under AXIL_MASTER_STATS_EN.

## Test plan
- Write 0x0000 ← 32'h0000_0005, wstrb 4'hF, zero-wait slave
  - AW and W both handshake in cycle 1.
  - rsp_valid in cycle 3 with rsp_write = 1, rsp_resp = 2'b00.
  - wr_count = 1.
- Read 0x0004 with the slave returning 32'hDEAD_BEEF after RVALID is delayed 5 cycles
  - RREADY is held high throughout.
  - rsp_rdata = 32'hDEAD_BEEF, rsp_resp = 2'b00, rd_count = 1.
- Write with AWREADY in cycle 1 and WREADY delayed to cycle 4, slave pre-asserting BVALID
  - AWVALID drops after cycle 1; WVALID is held until cycle 4.
  - BREADY first rises in cycle 5.
- Read of unmapped address 0x01FC with the slave answering RRESP = 2'b11
  - rsp_resp = 2'b11 and err_count = 1.
  - The block returns to IDLE after rsp_ready.
- Hold rsp_ready = 0 for 10 cycles after a read
  - rsp_valid and rsp_rdata stay stable; cmd_ready stays 0.
  - A cmd_valid pulse in that window is not accepted.
- Assert M_AXI_ARESET while ARVALID = 1
  - ARVALID = 0 in the same cycle; no response is emitted.
  - The next command after reset completes normally.

Source files
------------

// File: rtl/axil_master_pkg.sv
// Shared types and constants for the AXI4-Lite command initiator.
package axil_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } axil_master_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int STAT_W = 16;

endpackage

// File: rtl/axil_master_cmd_if.sv
// AXI4-Lite bus bundle; master modport drives AW/W/AR and the B/R ready signals.
interface axil_master_cmd_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   M_AXI_AWADDR;
    logic [2:0]          M_AXI_AWPROT;
    logic                M_AXI_AWVALID;
    logic                M_AXI_AWREADY;
    logic [DATA_W-1:0]   M_AXI_WDATA;
    logic [DATA_W/8-1:0] M_AXI_WSTRB;
    logic                M_AXI_WVALID;
    logic                M_AXI_WREADY;
    logic [1:0]          M_AXI_BRESP;
    logic                M_AXI_BVALID;
    logic                M_AXI_BREADY;
    logic [ADDR_W-1:0]   M_AXI_ARADDR;
    logic [2:0]          M_AXI_ARPROT;
    logic                M_AXI_ARVALID;
    logic                M_AXI_ARREADY;
    logic [DATA_W-1:0]   M_AXI_RDATA;
    logic [1:0]          M_AXI_RRESP;
    logic                M_AXI_RVALID;
    logic                M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/axil_master_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module axil_master_sat_counter
    import axil_master_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [STAT_W-1:0] count
);
    logic [STAT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/axil_master_cmd.sv
// Single-outstanding AXI4-Lite initiator driven by a cmd/rsp port.
// Define AXIL_MASTER_STATS_EN to build the wr/rd/err statistics counters.
module axil_master_cmd
    import axil_master_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 9,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    axil_master_cmd_if.master               m_axi,
    output logic [STAT_W-1:0]               wr_count,
    output logic [STAT_W-1:0]               rd_count,
    output logic [STAT_W-1:0]               err_count
);
    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

    axil_master_state_t state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STRB_W-1:0]             wstrb_q, wstrb_d;
    logic                          aw_valid_q, aw_valid_d, w_valid_q, w_valid_d;
    logic                          aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                          b_ready_q, b_ready_d, ar_valid_q, ar_valid_d;
    logic                          r_ready_q, r_ready_d, cmd_ready_q, cmd_ready_d;
    logic                          rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
    logic [1:0]                    resp_q, resp_d;

    logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_fin, w_fin;

    assign cmd_hs = cmd_valid & cmd_ready_q;
    assign aw_hs  = aw_valid_q & m_axi.M_AXI_AWREADY;
    assign w_hs   = w_valid_q & m_axi.M_AXI_WREADY;
    assign b_hs   = b_ready_q & m_axi.M_AXI_BVALID;
    assign ar_hs  = ar_valid_q & m_axi.M_AXI_ARREADY;
    assign r_hs   = r_ready_q & m_axi.M_AXI_RVALID;
    // AW and W complete independently; either may finish first or both together.
    assign aw_fin = aw_done_q | aw_hs;
    assign w_fin  = w_done_q | w_hs;

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            b_ready_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            resp_q      <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            b_ready_q   <= b_ready_d;
            ar_valid_q  <= ar_valid_d;
            r_ready_q   <= r_ready_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            resp_q      <= resp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_hs) state_d = cmd_write ? WR_ADDR : RD_ADDR;
            WR_ADDR: if (aw_fin && w_fin) state_d = WR_RESP;
            WR_RESP: if (b_hs) state_d = RESP;
            RD_ADDR: if (ar_hs) state_d = RD_DATA;
            RD_DATA: if (r_hs) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every bus/response output is computed one cycle ahead and registered.
    always_comb begin
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        b_ready_d   = b_ready_q;
        ar_valid_d  = ar_valid_q;
        r_ready_d   = r_ready_q;
        cmd_ready_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        resp_d      = resp_q;
        case (state_q)
            IDLE: begin
                cmd_ready_d = ~cmd_hs;
                if (cmd_hs) begin
                    addr_d     = cmd_addr;
                    wdata_d    = cmd_wdata;
                    wstrb_d    = cmd_wstrb;
                    aw_valid_d = cmd_write;
                    w_valid_d  = cmd_write;
                    ar_valid_d = ~cmd_write;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end
            end
            WR_ADDR: begin
                if (aw_hs) begin
                    aw_valid_d = 1'b0;
                    aw_done_d  = 1'b1;
                end
                if (w_hs) begin
                    w_valid_d = 1'b0;
                    w_done_d  = 1'b1;
                end
                if (aw_fin && w_fin) b_ready_d = 1'b1;
            end
            WR_RESP: begin
                if (b_hs) begin
                    b_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rdata_d     = '0;
                    resp_d      = m_axi.M_AXI_BRESP;
                end
            end
            RD_ADDR: begin
                if (ar_hs) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    r_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rdata_d     = m_axi.M_AXI_RDATA;
                    resp_d      = m_axi.M_AXI_RRESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign cmd_ready           = cmd_ready_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_write           = rsp_write_q;
    assign rsp_rdata           = rdata_q;
    assign rsp_resp            = resp_q;
    assign m_axi.M_AXI_AWADDR  = addr_q;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_AWVALID = aw_valid_q;
    assign m_axi.M_AXI_WDATA   = wdata_q;
    assign m_axi.M_AXI_WSTRB   = wstrb_q;
    assign m_axi.M_AXI_WVALID  = w_valid_q;
    assign m_axi.M_AXI_BREADY  = b_ready_q;
    assign m_axi.M_AXI_ARADDR  = addr_q;
    assign m_axi.M_AXI_ARPROT  = 3'b000;
    assign m_axi.M_AXI_ARVALID = ar_valid_q;
    assign m_axi.M_AXI_RREADY  = r_ready_q;

`ifdef AXIL_MASTER_STATS_EN
    logic err_inc;
    assign err_inc = (b_hs & m_axi.M_AXI_BRESP[1]) | (r_hs & m_axi.M_AXI_RRESP[1]);

    axil_master_sat_counter u_wr_cnt (
        .clk(M_AXI_ACLK), .rst(M_AXI_ARESET), .inc(b_hs), .count(wr_count)
    );
    axil_master_sat_counter u_rd_cnt (
        .clk(M_AXI_ACLK), .rst(M_AXI_ARESET), .inc(r_hs), .count(rd_count)
    );
    axil_master_sat_counter u_err_cnt (
        .clk(M_AXI_ACLK), .rst(M_AXI_ARESET), .inc(err_inc), .count(err_count)
    );
`else
    assign wr_count  = '0;
    assign rd_count  = '0;
    assign err_count = '0;
`endif
endmodule
